// File: rtl/ising_maxcut_loader_pkg.sv
// Shared definitions for the max-cut loader: ising_axi register map, FSM states
// and write-kind selector used by the address generator.
package ising_maxcut_loader_pkg;

    localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0000;
    localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0004;
    localparam logic [31:0] START_ADDR       = 32'h0000_0008;
    localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000;
    localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_EDGES,
        ST_FIELD,
        ST_START,
        ST_RUN,
        ST_READ,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        WK_NONE,
        WK_CUTOFF,
        WK_MAX,
        WK_WEIGHT,
        WK_START
    } wr_kind_t;

    function automatic logic [31:0] phase_addr(input logic [31:0] k);
        return PHASE_ADDR_BASE + (k << 2);
    endfunction

endpackage

// File: rtl/ising_maxcut_loader_wr_addr_gen.sv
// Combinational write-address generator: maps a write kind and the (i, j)
// coupling indices onto the ising_axi register map.
module ising_wr_addr_gen
    import ising_maxcut_loader_pkg::*;
#(
    parameter int IW = 3
) (
    input  logic [IW-1:0] i,
    input  logic [IW-1:0] j,
    input  wr_kind_t      kind,
    output logic [31:0]   wr_addr
);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_addr = '0;
        unique case (kind)
            WK_CUTOFF: wr_addr = CTR_CUTOFF_ADDR;
            WK_MAX:    wr_addr = CTR_MAX_ADDR;
            WK_START:  wr_addr = START_ADDR;
            WK_WEIGHT: wr_addr = WEIGHT_ADDR_BASE + (32'(i) << 2) + (32'(j) << 13);
            default:   wr_addr = '0;
        endcase
    end

endmodule

// File: rtl/ising_maxcut_loader.sv
// Sequencer ahead of ising_axi: programs config, edge and field couplings from an
// edge stream, starts a run, reads phases back and returns a field-relative cut.
module ising_maxcut_loader
    import ising_maxcut_loader_pkg::*;
#(
    parameter int N     = 8,
    parameter int W_NEG = 0,
    parameter int W_POS = 2,
    parameter int RUN_W = 32,
    localparam int IW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             axi_rstn,
    input  logic             go,
    input  logic [IW-1:0]    num_nodes,
    input  logic [31:0]      ctr_cutoff,
    input  logic [31:0]      ctr_max,
    input  logic [31:0]      start_val,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic             edge_valid,
    output logic             edge_ready,
    input  logic [IW-1:0]    edge_i,
    input  logic [IW-1:0]    edge_j,
    input  logic             edge_last,
    output logic             wready,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wdata,
    output logic             arvalid_q,
    output logic [31:0]      araddr_q,
    input  logic [31:0]      rdata,
    output logic             busy,
    output logic             cut_valid,
    output logic [N-2:0]     cut_spins,
    output logic             bad_edge
);

    localparam logic [IW-1:0] FIELD_IDX = IW'(N - 1);

    state_t           state, state_n;
    logic             sub;              // second cycle of a two-cycle write/read pair
    logic [IW-1:0]    node_k, rd_idx, nn_q, ei_q, ej_q;
    logic             elast_q, ph_field;
    logic [31:0]      cutoff_q, max_q, start_q;
    logic [RUN_W-1:0] run_q, run_cnt;

    wr_kind_t         wr_kind;
    logic [IW-1:0]    wr_i, wr_j, rd_node;
    logic             edge_drop, ph;

    assign edge_drop = (edge_i == edge_j) || (edge_i >= nn_q) || (edge_j >= nn_q) ||
                       (edge_i == FIELD_IDX) || (edge_j == FIELD_IDX);
    assign ph        = (rdata >= cutoff_q);
    assign rd_node   = rd_idx - 1'b1;
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);

    ising_wr_addr_gen #(.IW(IW)) u_addr_gen (
        .i       (wr_i),
        .j       (wr_j),
        .kind    (wr_kind),
        .wr_addr (wr_addr)
    );

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) state <= ST_IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n    = state;
        wready     = 1'b0;
        wr_kind    = WK_NONE;
        wr_i       = '0;
        wr_j       = '0;
        wdata      = '0;
        edge_ready = 1'b0;
        arvalid_q  = 1'b0;
        araddr_q   = '0;
        cut_valid  = 1'b0;
        unique case (state)
            ST_IDLE: if (go) state_n = ST_CFG;
            ST_CFG: begin
                wready  = 1'b1;
                wr_kind = sub ? WK_MAX : WK_CUTOFF;
                wdata   = sub ? max_q : cutoff_q;
                if (sub) state_n = (nn_q == '0) ? ST_START : ST_EDGES;
            end
            ST_EDGES: begin
                if (!sub) begin
                    edge_ready = 1'b1;
                    if (edge_valid && !edge_drop) begin
                        wready  = 1'b1;
                        wr_kind = WK_WEIGHT;
                        wr_i    = edge_i;
                        wr_j    = edge_j;
                        wdata   = 32'(W_NEG);
                    end else if (edge_valid && edge_last) begin
                        state_n = ST_FIELD;
                    end
                end else begin
                    wready  = 1'b1;
                    wr_kind = WK_WEIGHT;
                    wr_i    = ej_q;
                    wr_j    = ei_q;
                    wdata   = 32'(W_NEG);
                    if (elast_q) state_n = ST_FIELD;
                end
            end
            ST_FIELD: begin
                wready  = 1'b1;
                wr_kind = WK_WEIGHT;
                wr_i    = sub ? FIELD_IDX : node_k;
                wr_j    = sub ? node_k : FIELD_IDX;
                wdata   = 32'(W_POS);
                if (sub && node_k == nn_q - 1'b1) state_n = ST_START;
            end
            ST_START: begin
                wready  = 1'b1;
                wr_kind = WK_START;
                wdata   = start_q;
                state_n = (run_q == '0) ? ST_READ : ST_RUN;
            end
            ST_RUN: if (run_cnt == run_q) state_n = ST_READ;
            ST_READ: begin
                arvalid_q = 1'b1;
                araddr_q  = phase_addr(32'((rd_idx == '0) ? FIELD_IDX : rd_node));
                if (sub && rd_idx == nn_q) state_n = ST_DONE;
            end
            ST_DONE: begin
                cut_valid = 1'b1;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only; a blocking = here would let readers in the same edge see new values.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            sub       <= 1'b0;
            node_k    <= '0;
            rd_idx    <= '0;
            nn_q      <= '0;
            ei_q      <= '0;
            ej_q      <= '0;
            elast_q   <= 1'b0;
            ph_field  <= 1'b0;
            cutoff_q  <= '0;
            max_q     <= '0;
            start_q   <= '0;
            run_q     <= '0;
            run_cnt   <= '0;
            cut_spins <= '0;
            bad_edge  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (go) begin
                    nn_q      <= num_nodes;
                    cutoff_q  <= ctr_cutoff;
                    max_q     <= ctr_max;
                    start_q   <= start_val;
                    run_q     <= run_cycles;
                    bad_edge  <= 1'b0;
                    cut_spins <= '0;
                    sub       <= 1'b0;
                    node_k    <= '0;
                    rd_idx    <= '0;
                end
                ST_CFG: sub <= ~sub;
                ST_EDGES: begin
                    if (!sub) begin
                        if (edge_valid && edge_drop) begin
                            bad_edge <= 1'b1;
                        end else if (edge_valid) begin
                            sub     <= 1'b1;
                            ei_q    <= edge_i;
                            ej_q    <= edge_j;
                            elast_q <= edge_last;
                        end
                    end else begin
                        sub <= 1'b0;
                    end
                end
                ST_FIELD: begin
                    sub <= ~sub;
                    if (sub) node_k <= node_k + 1'b1;
                end
                ST_START: run_cnt <= RUN_W'(1);
                ST_RUN:   run_cnt <= run_cnt + 1'b1;
                ST_READ: begin
                    sub <= ~sub;
                    // The field spin is read first so node bits can be made relative on arrival.
                    if (sub) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == '0) ph_field <= ph;
                        else              cut_spins[rd_node] <= ph ^ ph_field;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_maxcut_loader.sv
// Self-checking bench: scoreboard of expected writes, reads and cuts, checked by a
// negedge monitor against the loader driving a registered phase-memory model.
module tb_ising_maxcut_loader;
    import ising_maxcut_loader_pkg::*;

    logic        clk = 1'b0;
    logic        axi_rstn;
    logic        go;
    logic [2:0]  num_nodes;
    logic [31:0] ctr_cutoff, ctr_max, start_val, run_cycles;
    logic        edge_valid, edge_ready, edge_last;
    logic [2:0]  edge_i, edge_j;
    logic        wready, arvalid_q, busy, cut_valid, bad_edge;
    logic [31:0] wr_addr, wdata, araddr_q, rdata;
    logic [6:0]  cut_spins;

    ising_maxcut_loader #(.N(8), .W_NEG(0), .W_POS(2), .RUN_W(32)) dut (
        .clk(clk), .axi_rstn(axi_rstn), .go(go), .num_nodes(num_nodes),
        .ctr_cutoff(ctr_cutoff), .ctr_max(ctr_max), .start_val(start_val),
        .run_cycles(run_cycles), .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_i(edge_i), .edge_j(edge_j), .edge_last(edge_last), .wready(wready),
        .wr_addr(wr_addr), .wdata(wdata), .arvalid_q(arvalid_q), .araddr_q(araddr_q),
        .rdata(rdata), .busy(busy), .cut_valid(cut_valid), .cut_spins(cut_spins),
        .bad_edge(bad_edge)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; logic er; } wr_t;
    typedef struct { logic [6:0] cut; logic bad; } cut_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    cut_t        cq[$];

    int n_checks = 0, n_errors = 0;
    int cyc = 0, start_cyc = 0, nwr = 0, cuts_seen = 0, exp_run = 0;
    bit rd_half = 0, first_rd = 0;
    logic [31:0] cur_ra = '0;
    logic [31:0] mem [8];
    logic [31:0] roff;
    int ei_tab [8], ej_tab [8];

    // Phase memory with one cycle of read latency, like the array's read port.
    assign roff = (araddr_q - PHASE_ADDR_BASE) >> 2;
    always @(posedge clk) rdata <= mem[roff[2:0]];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] waddr(input int i, input int j);
        return WEIGHT_ADDR_BASE + 32'(i * 4) + 32'(j * 8192);
    endfunction

    always @(negedge clk) begin : monitor
        wr_t  e;
        cut_t c;
        if (axi_rstn) begin
            if (wready) begin
                nwr++;
                check("wr_expected", 64'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wdata", wdata, e.data);
                    check("edge_ready_in_write", edge_ready, e.er);
                end
                if (wr_addr == START_ADDR) start_cyc = cyc;
            end
            if (arvalid_q) begin
                if (!rd_half) begin
                    check("rd_expected", 64'(rq.size() != 0), 1);
                    if (rq.size() != 0) cur_ra = rq.pop_front();
                    check("araddr", araddr_q, cur_ra);
                    if (first_rd) begin
                        check("run_delay", 64'(cyc - start_cyc), 64'(exp_run + 1));
                        first_rd = 0;
                    end
                end else begin
                    check("araddr_hold", araddr_q, cur_ra);
                end
                rd_half = !rd_half;
            end
            if (cut_valid) begin
                check("cut_expected", 64'(cq.size() != 0), 1);
                if (cq.size() != 0) begin
                    c = cq.pop_front();
                    check("cut_spins", cut_spins, c.cut);
                    check("bad_edge", bad_edge, c.bad);
                end
                check("busy_at_done", busy, 0);
                cuts_seen++;
            end
        end
    end

    task automatic outputs_zero(input string tag);
        check({tag, "_wr"}, {wready, wr_addr}, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_rd"}, {arvalid_q, araddr_q}, 0);
        check({tag, "_misc"}, {busy, cut_valid, cut_spins, bad_edge, edge_ready}, 0);
    endtask

    task automatic send_edge(input int i, input int j, input bit last, input bit gap);
        bit got = 0;
        if (gap) begin
            repeat ($urandom_range(0, 3)) begin
                edge_i = 3'($urandom);
                edge_j = 3'($urandom);
                edge_last = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        edge_valid = 1; edge_i = 3'(i); edge_j = 3'(j); edge_last = last;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); got = edge_ready;
            @(posedge clk); #1;
            if (got) break;
        end
        edge_valid = 0; edge_last = 0;
        check("edge_accept", got, 1);
    endtask

    task automatic run_problem(input int nn, input logic [31:0] cutoff, input logic [31:0] maxv,
                               input logic [31:0] sv, input int run, input int ne,
                               input bit gap, input bit poke, input bit abort);
        logic [6:0] exp_cut = '0;
        logic bad = 0, fph;
        int nw = 0, seen;
        bit got = 0;
        wq.push_back('{CTR_CUTOFF_ADDR, cutoff, 1'b0});
        wq.push_back('{CTR_MAX_ADDR, maxv, 1'b0});
        nw = 2;
        for (int e = 0; e < ne; e++) begin
            if (ei_tab[e] == ej_tab[e] || ei_tab[e] >= nn || ej_tab[e] >= nn ||
                ei_tab[e] == 7 || ej_tab[e] == 7) begin
                bad = 1;
            end else begin
                wq.push_back('{waddr(ei_tab[e], ej_tab[e]), 32'd0, 1'b1});
                wq.push_back('{waddr(ej_tab[e], ei_tab[e]), 32'd0, 1'b0});
                nw += 2;
            end
        end
        for (int k = 0; k < nn; k++) begin
            wq.push_back('{waddr(k, 7), 32'd2, 1'b0});
            wq.push_back('{waddr(7, k), 32'd2, 1'b0});
            nw += 2;
        end
        wq.push_back('{START_ADDR, sv, 1'b0});
        nw++;
        rq.push_back(PHASE_ADDR_BASE + 32'h1C);
        for (int k = 0; k < nn; k++) rq.push_back(PHASE_ADDR_BASE + 32'(4 * k));
        fph = (mem[7] >= cutoff);
        for (int k = 0; k < nn; k++) exp_cut[k] = (mem[k] >= cutoff) ^ fph;
        cq.push_back('{exp_cut, bad});
        exp_run = run; nwr = 0; first_rd = 1; seen = cuts_seen;

        @(posedge clk); #1;
        go = 1; num_nodes = 3'(nn); ctr_cutoff = cutoff; ctr_max = maxv;
        start_val = sv; run_cycles = 32'(run);
        @(posedge clk); #1;
        go = 0; num_nodes = 3'(7 - nn); ctr_cutoff = ~cutoff; ctr_max = ~maxv;
        start_val = ~sv; run_cycles = 32'(run + 3);
        @(negedge clk);
        check("busy_after_go", busy, 1);
        @(posedge clk); #1;
        for (int e = 0; e < ne; e++) send_edge(ei_tab[e], ej_tab[e], e == ne - 1, gap);
        if (poke) begin
            go = 1; num_nodes = 3'd1; ctr_cutoff = 32'd0;
            @(posedge clk); #1;
            go = 0;
        end
        if (abort) begin
            for (int t = 0; t < 2000; t++) begin
                @(negedge clk);
                if (wready && wdata == 32'd2) begin got = 1; break; end
            end
            check("reach_field", got, 1);
            #1 axi_rstn = 0;
            @(negedge clk);
            outputs_zero("abort");
            wq.delete(); rq.delete(); cq.delete(); rd_half = 0; first_rd = 0;
            @(negedge clk);
            axi_rstn = 1;
        end else begin
            for (int t = 0; t < 5000 && cuts_seen == seen; t++) @(negedge clk);
            check("cut_seen", 64'(cuts_seen != seen), 1);
            @(negedge clk);
            check("nwrites", 64'(nwr), 64'(nw));
            check("wq_drained", 64'(wq.size()), 0);
            check("rq_drained", 64'(rq.size()), 0);
            check("cq_drained", 64'(cq.size()), 0);
        end
    endtask

    task automatic load_t1_edges();
        ei_tab[0] = 0; ej_tab[0] = 1;
        ei_tab[1] = 0; ej_tab[1] = 4;
        ei_tab[2] = 1; ej_tab[2] = 2;
        ei_tab[3] = 1; ej_tab[3] = 3;
        ei_tab[4] = 2; ej_tab[4] = 3;
        ei_tab[5] = 3; ej_tab[5] = 4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axi_rstn = 0; go = 0; num_nodes = 0; ctr_cutoff = 0; ctr_max = 0;
        start_val = 0; run_cycles = 0; edge_valid = 0; edge_i = 0; edge_j = 0; edge_last = 0;
        // Node phases: 0,2,3 at/above cutoff 4 (node 0 exactly at it), 1,4 below; 5,6 unused.
        mem[0] = 4; mem[1] = 2; mem[2] = 9; mem[3] = 6; mem[4] = 0;
        mem[5] = 100; mem[6] = 100; mem[7] = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outputs_zero("reset");
        axi_rstn = 1;
        @(posedge clk); #1;
        edge_valid = 1; edge_i = 0; edge_j = 1;
        repeat (2) begin
            @(negedge clk);
            check("idle_edge_ready", {edge_ready, wready}, 0);
        end
        @(posedge clk); #1;
        edge_valid = 0;

        load_t1_edges();
        run_problem(5, 32'd4, 32'd8, 32'h10, 500, 6, 0, 0, 0);

        ei_tab[0] = 2; ej_tab[0] = 2;
        ei_tab[1] = 5; ej_tab[1] = 1;
        ei_tab[2] = 7; ej_tab[2] = 0;
        mem[7] = 50;
        run_problem(5, 32'd4, 32'd8, 32'h10, 5, 3, 0, 0, 0);

        mem[7] = 3;
        load_t1_edges();
        run_problem(5, 32'd4, 32'd8, 32'h10, 500, 6, 1, 0, 0);

        run_problem(0, 32'd4, 32'd8, 32'h10, 7, 0, 0, 0, 0);

        run_problem(5, 32'd4, 32'd8, 32'h10, 500, 6, 0, 0, 1);
        run_problem(5, 32'd4, 32'd8, 32'h10, 500, 6, 0, 1, 0);

        ei_tab[0] = 0; ej_tab[0] = 1;
        run_problem(2, 32'd3, 32'd9, 32'h55, 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
